key_conditioner: RTL and testbench

Conditions raw, asynchronous push-button/keyboard strobes into clean single-cycle key events for the Tetris game.
- Per key: 2-flop synchronizer, counter-based debounce, rising-edge pulse, and optional held-key auto-repeat (DAS) for piece movement.
- Sits directly upstream of the game state FSM. any_press drives the FSM's user input.
- key_press drives the piece-movement logic. play is the FSM's PLAY state decode (state == 2'b01).

---
 rtl/key_conditioner.sv | 163 ++++++++++++++++
 tb/tb_key_conditioner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Raw key strobes -> synchronized, debounced levels, single-cycle press pulses and optional DAS auto-repeat.
// Optional feature macro: KEY_REPEAT_EN (per-key repeat FSMs; when undefined key_press carries initial presses only).
//
// Repeat FSM states:
//   state     | meaning
//   ST_IDLE   | no repeat in progress
//   ST_DELAY  | key held in PLAY, counting the initial auto-repeat delay
//   ST_REPEAT | key still held, emitting a pulse every REPEAT_PERIOD cycles
module key_conditioner #(
    parameter int                  NUM_KEYS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 250000,
    parameter int                  REPEAT_DELAY    = 10000000,
    parameter int                  REPEAT_PERIOD   = 2500000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = NUM_KEYS'(4'b0011)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                play,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                any_press
);

    localparam int             DCW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_level;
    logic [NUM_KEYS-1:0] r_press;
    logic                r_any;
    logic [DCW-1:0]      r_deb_cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_expire;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_fall;
    logic [NUM_KEYS-1:0] w_rep_pulse;

    // A level update happens on the edge the mismatch has lasted DEBOUNCE_CYCLES edges.
    always_comb begin
        w_expire = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_expire[i] = (r_sync2[i] != r_level[i]) && (r_deb_cnt[i] == DEB_LAST);
        end
        w_rise = w_expire & r_sync2;
        w_fall = w_expire & ~r_sync2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_press <= '0;
            r_any   <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_expire[i]) begin
                    r_level[i]   <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
            r_press <= w_rise | w_rep_pulse;
            r_any   <= |w_rise;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int             RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RCW      = $clog2(RMAX + 1);
    localparam logic [RCW-1:0] DLY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PER_LAST = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    rep_state_t     r_state [NUM_KEYS];
    logic [RCW-1:0] r_rc    [NUM_KEYS];

    // Leaving PLAY or releasing the key wins over a simultaneous counter expiry.
    always_comb begin
        w_rep_pulse = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (play && !w_fall[i]) begin
                if ((r_state[i] == ST_DELAY) && (r_rc[i] == DLY_LAST)) begin
                    w_rep_pulse[i] = 1'b1;
                end
                if ((r_state[i] == ST_REPEAT) && (r_rc[i] == PER_LAST)) begin
                    w_rep_pulse[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= ST_IDLE;
                r_rc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_rise[i] && play && REPEAT_MASK[i]) begin
                            r_state[i] <= ST_DELAY;
                            r_rc[i]    <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (w_fall[i] || !play) begin
                            r_state[i] <= ST_IDLE;
                            r_rc[i]    <= '0;
                        end else if (r_rc[i] == DLY_LAST) begin
                            r_state[i] <= ST_REPEAT;
                            r_rc[i]    <= '0;
                        end else begin
                            r_rc[i] <= r_rc[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_fall[i] || !play) begin
                            r_state[i] <= ST_IDLE;
                            r_rc[i]    <= '0;
                        end else if (r_rc[i] == PER_LAST) begin
                            r_rc[i] <= '0;
                        end else begin
                            r_rc[i] <= r_rc[i] + 1'b1;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                        r_rc[i]    <= '0;
                    end
                endcase
            end
        end
    end
`else
    // Without auto-repeat, play and the repeat parameters have no effect.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{play, REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign w_rep_pulse  = '0;
`endif

    assign key_level = r_level;
    assign key_press = r_press;
    assign any_press = r_any;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed scenarios then random key/play/reset traffic
// checked against an event-level reference model.
module tb_key_conditioner;

    localparam int         NK   = 4;
    localparam int         DEB  = 4;
    localparam int         RD   = 8;
    localparam int         RP   = 3;
    localparam logic [3:0] MASK = 4'b0011;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic          play;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic          any_press;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .play     (play),
        .key_level(key_level),
        .key_press(key_press),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          cyc;
        logic [NK-1:0] press;
        logic        any;
    } ev_t;
    typedef struct {
        int          cyc;
        logic [NK-1:0] lvl;
    } lv_t;

    ev_t ev_q[$];
    lv_t lv_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    // Reference model state: synchronizer pipe, debounced level, mismatch run length,
    // and per-key repeat bookkeeping (active flag + cycle of the initial press).
    logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    int            m_run [NK];
    bit            m_act [NK];
    int            m_tp  [NK];

    task automatic model_step(input logic [NK-1:0] raw, input logic pl, input logic rst);
        int            e;
        int            d;
        bit            rise, fall;
        logic [NK-1:0] pr;
        logic          anyp;
        e    = cyc + 1;
        pr   = '0;
        anyp = 1'b0;
        if (rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            for (int i = 0; i < NK; i++) begin
                m_run[i] = 0;
                m_act[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NK; i++) begin
                rise = 1'b0;
                fall = 1'b0;
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_run[i] = 0;
                        if (m_s2[i]) rise = 1'b1;
                        else         fall = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (rise) begin
                    pr[i] = 1'b1;
                    anyp  = 1'b1;
                end
                if (REP_EN) begin
                    if (m_act[i]) begin
                        if (fall || !pl) begin
                            m_act[i] = 1'b0;
                        end else begin
                            d = e - m_tp[i];
                            if (d == RD || (d > RD && ((d - RD) % RP) == 0)) pr[i] = 1'b1;
                        end
                    end else if (rise && pl && MASK[i]) begin
                        m_act[i] = 1'b1;
                        m_tp[i]  = e;
                    end
                end
                if (rise) m_lvl[i] = 1'b1;
                if (fall) m_lvl[i] = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        lv_q.push_back('{e, m_lvl});
        if (pr != '0 || anyp) ev_q.push_back('{e, pr, anyp});
    endtask

    // Drive one cycle of inputs, record expectations for the coming edge, wait past it.
    task automatic step(input logic [NK-1:0] raw, input logic pl, input logic rst);
        key_raw = raw;
        play    = pl;
        reset   = rst;
        model_step(raw, pl, rst);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [NK-1:0] raw, input logic pl, input logic rst);
        for (int k = 0; k < n; k++) step(raw, pl, rst);
    endtask

    bit mon_en = 1'b1;

    always @(negedge clk) begin
        ev_t e;
        lv_t l;
        if (mon_en) begin
            while (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
                l = lv_q.pop_front();
                n_checks++;
                if (l.cyc != cyc) begin
                    n_errors++;
                    $display("FAIL level_sample cycle %0d: expectation for cycle %0d was never compared", cyc, l.cyc);
                end else if (key_level !== l.lvl) begin
                    n_errors++;
                    $display("FAIL key_level cycle %0d: got %b expected %b", cyc, key_level, l.lvl);
                end
            end
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                e = ev_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missed_pulse cycle %0d: expected press %b any %b, nothing seen", e.cyc, e.press, e.any);
            end
            if (key_press !== '0 || any_press !== 1'b0) begin
                n_checks++;
                if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                    e = ev_q.pop_front();
                    if (key_press !== e.press || any_press !== e.any) begin
                        n_errors++;
                        $display("FAIL pulse cycle %0d: got press %b any %b expected press %b any %b",
                                 cyc, key_press, any_press, e.press, e.any);
                    end
                end else begin
                    n_errors++;
                    $display("FAIL unexpected_pulse cycle %0d: got press %b any %b expected none",
                             cyc, key_press, any_press);
                end
            end else if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e = ev_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missed_pulse cycle %0d: got press %b any %b expected press %b any %b",
                         cyc, key_press, any_press, e.press, e.any);
            end
        end
    end

    initial begin
        int            rem [NK];
        logic [NK-1:0] raw;
        logic          pl;
        logic          rst;

        for (int i = 0; i < NK; i++) begin
            m_run[i] = 0;
            m_act[i] = 1'b0;
            m_tp[i]  = 0;
        end

        // Reset, then a clean press of rotate outside PLAY.
        hold(3, 4'b0000, 1'b0, 1'b1);
        hold(4, 4'b0000, 1'b0, 1'b0);
        hold(20, 4'b0100, 1'b0, 1'b0);
        hold(12, 4'b0000, 1'b0, 1'b0);

        // Bounce on left: toggling every 2 cycles never settles long enough.
        for (int k = 0; k < 6; k++) begin
            hold(2, 4'b0001, 1'b0, 1'b0);
            hold(2, 4'b0000, 1'b0, 1'b0);
        end
        hold(10, 4'b0000, 1'b0, 1'b0);

        // Auto-repeat on right in PLAY.
        hold(30, 4'b0010, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);

        // Release race: left falls on the same edge its first repeat would fire.
        hold(8, 4'b0001, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);
        // Drop key (not repeat-enabled) held long.
        hold(40, 4'b1000, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);

        // play drop while held, re-raise, release and re-press.
        hold(18, 4'b0010, 1'b1, 1'b0);
        hold(6, 4'b0010, 1'b0, 1'b0);
        hold(15, 4'b0010, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);
        hold(25, 4'b0010, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);

        // Reset mid-hold, key still held through reset release.
        hold(14, 4'b0010, 1'b1, 1'b0);
        hold(1, 4'b0010, 1'b1, 1'b1);
        hold(25, 4'b0010, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);

        // Several keys pressed together.
        hold(20, 4'b1111, 1'b1, 1'b0);
        hold(12, 4'b0000, 1'b1, 1'b0);

        // Random traffic: per-key runs of random length, occasional play flips and resets.
        raw = '0;
        pl  = 1'b1;
        for (int i = 0; i < NK; i++) rem[i] = $urandom_range(1, 30);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NK; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    raw[i] = ~raw[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
                end
            end
            if ($urandom_range(0, 49) == 0) pl = ~pl;
            rst = ($urandom_range(0, 299) == 0);
            step(raw, pl, rst);
        end
        hold(15, 4'b0000, 1'b0, 1'b0);

        // Let the monitor consume the last expectations.
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        n_checks++;
        if (ev_q.size() != 0 || lv_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pulse and %0d level expectations left, expected 0 and 0",
                     ev_q.size(), lv_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
